// File: rtl/wb_ps2.sv
// wb_ps2: PS/2 device-to-host receiver with a Wishbone slave register interface.
// Both pins are synchronised and the PS/2 clock is debounced. 11-bit frames are
// deframed, and good bytes are queued in a small FIFO that a DATA read pops.
// Sticky error flags and the interrupt enable live in STATUS.
module wb_ps2 #(
   parameter int DEPTH   = 8,
   parameter int FILTER  = 8,
   parameter int TIMEOUT = 100000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ps2_clk,
   input  logic        ps2_dat,
   input  logic        cyc_i,
   input  logic        stb_i,
   input  logic        we_i,
   input  logic        adr_i,
   input  logic [3:0]  sel_i,
   input  logic [31:0] dat_i,
   output logic        ack_o,
   output logic [31:0] dat_o,
   output logic        irq
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = $clog2(FILTER + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   // synchronisers
   logic clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
   logic dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
   // clock filter
   logic          filt_clk_q, filt_clk_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic          fall_q, fall_d;
   // deframer
   logic [1:0]    state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_ok_q, par_ok_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          push_q, push_d;
   logic          ferr_set, perr_set;
   // fifo
   logic [7:0]    mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
   logic          fifo_empty, fifo_full, do_push, pop, ovf_set;
   logic [7:0]    head_byte;
   // register interface
   logic          ack_q, ack_d;
   logic [31:0]   dat_o_q, dat_o_d;
   logic          irq_q, irq_d;
   logic          irqen_q, irqen_d;
   logic          ferr_q, ferr_d, perr_q, perr_d, ovf_q, ovf_d;
   logic          req, stat_wr;
   logic [2:0]    clr;
   logic [31:0]   status_word;
   logic          dat_unused;

   // Only the flag-clear and IRQEN bits of a write carry meaning.
   assign dat_unused = ^{dat_i[31:17], dat_i[15:11], dat_i[7:0], sel_i[3], sel_i[0]};

   // Two-stage synchronisers for both raw pins.
   always_comb begin
      clk_s1_d = ps2_clk;
      clk_s2_d = clk_s1_q;
      dat_s1_d = ps2_dat;
      dat_s2_d = dat_s1_q;
   end

   // Debounce: the filtered clock follows only after FILTER equal samples
   // that differ from it; a 1->0 change emits the one-cycle fall pulse.
   always_comb begin
      filt_clk_d = filt_clk_q;
      filt_cnt_d = '0;
      fall_d     = 1'b0;
      if (clk_s2_q != filt_clk_q) begin
         if (filt_cnt_q == FW'(FILTER - 1)) begin
            filt_clk_d = clk_s2_q;
            fall_d     = ~clk_s2_q;
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end
   end

   // Frame deframer with an inactivity timeout while a frame is in progress.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_ok_d  = par_ok_q;
      tmo_d     = tmo_q;
      push_d    = 1'b0;
      ferr_set  = 1'b0;
      perr_set  = 1'b0;
      if (fall_q) begin
         tmo_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (!dat_s2_q) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            ST_DATA: begin
               shift_d   = {dat_s2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
            end
            ST_PARITY: begin
               par_ok_d = ^{shift_q, dat_s2_q};
               state_d  = ST_STOP;
            end
            default: begin
               state_d = ST_IDLE;
               if (!dat_s2_q)      ferr_set = 1'b1;
               else if (!par_ok_q) perr_set = 1'b1;
               else                push_d   = 1'b1;
            end
         endcase
      end else if (state_q != ST_IDLE) begin
         if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d  = ST_IDLE;
            ferr_set = 1'b1;
            tmo_d    = '0;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end else begin
         tmo_d = '0;
      end
   end

   // FIFO bookkeeping, bus decode, sticky flags and interrupt.
   always_comb begin
      fifo_empty = (count_q == '0);
      fifo_full  = (count_q == (AW + 1)'(DEPTH));
      req        = cyc_i & stb_i & ~ack_q;
      stat_wr    = req & we_i & adr_i;
      pop        = req & ~we_i & ~adr_i & ~fifo_empty;
      do_push    = push_q & (~fifo_full | pop);
      ovf_set    = push_q & fifo_full & ~pop;
      head_byte  = fifo_empty ? 8'd0 : mem_q[rd_ptr_q[AW-1:0]];

      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
      count_d  = count_q;
      if (do_push && !pop)      count_d = count_q + 1'b1;
      else if (!do_push && pop) count_d = count_q - 1'b1;

      status_word = {15'd0, irqen_q, 5'd0, ferr_q, perr_q, ovf_q,
                     {(7 - AW){1'b0}}, count_q};

      ack_d   = req;
      dat_o_d = 32'd0;
      if (req && !we_i) begin
         if (adr_i) dat_o_d = status_word;
         else       dat_o_d = {23'd0, ~fifo_empty, head_byte};
      end

      clr     = (stat_wr && sel_i[1]) ? dat_i[10:8] : 3'b000;
      ferr_d  = ferr_set | (ferr_q & ~clr[2]);
      perr_d  = perr_set | (perr_q & ~clr[1]);
      ovf_d   = ovf_set  | (ovf_q  & ~clr[0]);
      irqen_d = (stat_wr && sel_i[2]) ? dat_i[16] : irqen_q;
      irq_d   = irqen_q & ~fifo_empty;
   end

   // State registers; synchronisers and filtered clock idle high.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
         filt_clk_q <= 1'b1;
         filt_cnt_q <= '0;
         fall_q     <= 1'b0;
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'd0;
         par_ok_q   <= 1'b0;
         tmo_q      <= '0;
         push_q     <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ack_q      <= 1'b0;
         dat_o_q    <= 32'd0;
         irq_q      <= 1'b0;
         irqen_q    <= 1'b0;
         ferr_q     <= 1'b0;
         perr_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         clk_s1_q   <= clk_s1_d;
         clk_s2_q   <= clk_s2_d;
         dat_s1_q   <= dat_s1_d;
         dat_s2_q   <= dat_s2_d;
         filt_clk_q <= filt_clk_d;
         filt_cnt_q <= filt_cnt_d;
         fall_q     <= fall_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_ok_q   <= par_ok_d;
         tmo_q      <= tmo_d;
         push_q     <= push_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ack_q      <= ack_d;
         dat_o_q    <= dat_o_d;
         irq_q      <= irq_d;
         irqen_q    <= irqen_d;
         ferr_q     <= ferr_d;
         perr_q     <= perr_d;
         ovf_q      <= ovf_d;
      end
   end

   // FIFO storage; the byte stays in shift_q through the push cycle.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
   end

   assign ack_o = ack_q;
   assign dat_o = dat_o_q;
   assign irq   = irq_q;

endmodule

// File: tb/tb_wb_ps2.sv
// tb_wb_ps2: directed stimulus for wb_ps2 with a byte scoreboard and a small
// flag/count model predicting DATA and STATUS reads.
module tb_wb_ps2;

   localparam int DEPTH   = 8;
   localparam int FILTER  = 8;
   localparam int TIMEOUT = 1000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_dat = 1'b1;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, adr = 1'b0;
   logic [3:0]  sel = 4'd0;
   logic [31:0] wdat = 32'd0;
   logic        ack_o;
   logic [31:0] dat_o;
   logic        irq;

   int checks = 0;
   int errors = 0;

   // scoreboard of bytes expected from the FIFO, plus modelled STATUS bits
   logic [7:0] exp_q[$];
   logic m_irqen = 1'b0, m_ferr = 1'b0, m_perr = 1'b0, m_ovf = 1'b0;

   wb_ps2 #(.DEPTH(DEPTH), .FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk), .rst_i(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
      .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr), .sel_i(sel),
      .dat_i(wdat), .ack_o(ack_o), .dat_o(dat_o), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_status();
      logic [7:0] cnt;
      cnt = 8'(exp_q.size());
      return {15'd0, m_irqen, 5'd0, m_ferr, m_perr, m_ovf, cnt};
   endfunction

   // one Wishbone access; returns the data captured in the ack cycle
   task automatic wb_access(input logic w, input logic a, input logic [3:0] s,
                            input logic [31:0] d, output logic [31:0] rd);
      logic got;
      int   n;
      got = 1'b0;
      n   = 0;
      rd  = 32'd0;
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
      while (!got && n < 8) begin
         @(posedge clk); #1;
         n++;
         if (ack_o) begin
            got = 1'b1;
            rd  = dat_o;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'd0; wdat = 32'd0;
      check("ack_arrived", {31'd0, got}, 32'd1);
   endtask

   task automatic read_status(input string tag);
      logic [31:0] rd;
      wb_access(1'b0, 1'b1, 4'hF, 32'd0, rd);
      check(tag, rd, exp_status());
   endtask

   task automatic read_data(input string tag);
      logic [31:0] rd, exp;
      wb_access(1'b0, 1'b0, 4'hF, 32'd0, rd);
      if (exp_q.size() > 0) exp = {23'd0, 1'b1, exp_q.pop_front()};
      else                  exp = 32'd0;
      check(tag, rd, exp);
      $display("DATA read %s: %h", tag, rd);
   endtask

   task automatic write_reg(input logic a, input logic [3:0] s, input logic [31:0] d);
      logic [31:0] rd;
      wb_access(1'b1, a, s, d, rd);
      $display("WRITE adr=%0d sel=%b data=%h", a, s, d);
   endtask

   // one PS/2 bit: data set while clock is high, then a 20-cycle low phase
   task automatic ps2_bit(input logic b, input logic glitch);
      ps2_dat = b;
      repeat (4) @(posedge clk);
      if (glitch) begin
         ps2_clk = 1'b0;
         repeat (3) @(posedge clk);
         ps2_clk = 1'b1;
      end
      repeat (10) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (20) @(posedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par,
                             input logic bad_stop, input logic glitch);
      ps2_bit(1'b0, glitch);
      for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
      ps2_bit((~^b) ^ bad_par, glitch);
      ps2_bit(~bad_stop, glitch);
      ps2_dat = 1'b1;
      repeat (20) @(posedge clk);
      $display("FRAME sent %h bad_par=%0d bad_stop=%0d glitch=%0d", b, bad_par, bad_stop, glitch);
   endtask

   // good frame: scoreboard push, or overflow when the model FIFO is full
   task automatic send_good(input logic [7:0] b, input logic glitch);
      send_frame(b, 1'b0, 1'b0, glitch);
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else                      m_ovf = 1'b1;
   endtask

   initial begin
      // reset
      repeat (3) @(posedge clk);
      check("rst_dat_o", dat_o, 32'd0);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk); #1;
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_ack", {31'd0, ack_o}, 32'd0);
      read_status("rst_status");
      read_data("rst_data");

      // single frame with interrupt enabled
      write_reg(1'b1, 4'b0100, 32'h0001_0000);
      m_irqen = 1'b1;
      send_good(8'h1C, 1'b0);
      #1 check("irq_after_push", {31'd0, irq}, 32'd1);
      read_status("status_one");
      read_data("data_1c");
      check("irq_still_high", {31'd0, irq}, 32'd1);
      @(posedge clk); #1;
      check("irq_after_pop", {31'd0, irq}, 32'd0);
      read_status("status_empty");

      // DATA writes are ignored
      write_reg(1'b0, 4'hF, 32'hFFFF_FFFF);
      read_status("status_after_data_wr");

      // overflow: nine frames into eight entries
      for (int i = 1; i <= 9; i++) send_good(8'(i), 1'b0);
      read_status("status_ovf");
      write_reg(1'b1, 4'b0001, 32'h0000_0100);
      read_status("status_ovf_sel0_kept");
      for (int i = 0; i < 8; i++) read_data("data_fifo");
      read_data("data_empty");
      write_reg(1'b1, 4'b0010, 32'h0000_0100);
      m_ovf = 1'b0;
      read_status("status_ovf_clr");

      // parity and framing errors
      send_frame(8'h55, 1'b1, 1'b0, 1'b0);
      m_perr = 1'b1;
      read_status("status_perr");
      send_frame(8'h33, 1'b0, 1'b1, 1'b0);
      ps2_dat = 1'b1;
      m_ferr = 1'b1;
      read_status("status_ferr");
      write_reg(1'b1, 4'b0010, 32'h0000_0700);
      m_ferr = 1'b0; m_perr = 1'b0;
      read_status("status_flags_clr");

      // timeout mid-frame
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
      ps2_dat = 1'b1;
      repeat (TIMEOUT + 10) @(posedge clk);
      m_ferr = 1'b1;
      read_status("status_timeout");
      send_good(8'hAA, 1'b0);
      read_data("data_aa");
      write_reg(1'b1, 4'b0010, 32'h0000_0400);
      m_ferr = 1'b0;

      // glitches on an idle line, then inside a frame
      for (int i = 0; i < 3; i++) begin
         ps2_clk = 1'b0;
         repeat (3) @(posedge clk);
         ps2_clk = 1'b1;
         repeat (10) @(posedge clk);
      end
      repeat (30) @(posedge clk); #1;
      check("irq_idle_glitch", {31'd0, irq}, 32'd0);
      read_status("status_idle_glitch");
      send_good(8'hF0, 1'b1);
      read_status("status_glitch_frame");
      read_data("data_f0");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
